pipe_arb_mux: RTL

- Registered N-input, W-bit multiplexer with a valid/ready handshake on every input and on the output.
- The input is chosen either by an explicit select or by a built-in round-robin arbiter.
- Generalises the team's combinational 2/3-way mux for shared-resource paths, e.g. writeback-bus sharing and memory-port sharing between fetch and load/store.
- Output is one register stage: latency 1, full throughput.

---
 rtl/pipe_arb_mux.sv | 106 ++++++++++
 1 files changed

// File: rtl/pipe_arb_mux.sv
// Registered N-way multiplexer with valid/ready on every channel; the source is picked
// by an explicit select (MODE=0) or by a round-robin arbiter over valid inputs (MODE=1).
module pipe_arb_mux #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int MODE   = 0,
    parameter int SELW   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SELW-1:0]           sel,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    input  logic [NUM_IN-1:0]         in_valid,
    output logic [NUM_IN-1:0]         in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic [SELW-1:0]           out_src,
    input  logic                      out_ready
);

    // Channel tables are padded to the full select range so an out-of-range sel
    // simply reads an idle, zero-data channel.
    localparam int NSEL = 1 << SELW;

    logic [WIDTH-1:0] ch_data [NSEL];
    logic [NSEL-1:0]  valid_pad;

    logic [WIDTH-1:0] out_data_reg;
    logic             out_valid_reg;
    logic [SELW-1:0]  out_src_reg;
    logic [SELW-1:0]  last_reg;

    logic             sel_grant;
    logic             rr_grant;
    logic [SELW-1:0]  rr_idx;
    logic             grant;
    logic [SELW-1:0]  grant_idx;
    logic             load_en;
    logic             xfer;

    genvar gi;
    generate
        for (gi = 0; gi < NSEL; gi++) begin : g_ch
            if (gi < NUM_IN) begin : g_real
                assign ch_data[gi]   = in_data[gi*WIDTH +: WIDTH];
                assign valid_pad[gi] = in_valid[gi];
            end else begin : g_pad
                assign ch_data[gi]   = '0;
                assign valid_pad[gi] = 1'b0;
            end
        end
    endgenerate

    // Round-robin search starts one past the last granted channel and wraps.
    always_comb begin
        int idx;
        idx      = 0;
        rr_grant = 1'b0;
        rr_idx   = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = int'(last_reg) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (!rr_grant && valid_pad[idx]) begin
                rr_grant = 1'b1;
                rr_idx   = SELW'(idx);
            end
        end
    end

    assign sel_grant = valid_pad[sel];
    assign grant     = (MODE == 1) ? rr_grant : sel_grant;
    assign grant_idx = (MODE == 1) ? rr_idx   : sel;
    assign load_en   = !out_valid_reg || out_ready;
    assign xfer      = grant && load_en && !rst;

    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_ready
            assign in_ready[gi] = xfer && (grant_idx == SELW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_src_reg   <= '0;
            last_reg      <= SELW'(NUM_IN - 1);
        end else if (xfer) begin
            out_data_reg  <= ch_data[grant_idx];
            out_valid_reg <= 1'b1;
            out_src_reg   <= grant_idx;
            if (MODE == 1) begin
                last_reg <= grant_idx;
            end
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_src   = out_src_reg;

endmodule
